// File: rtl/cevero_mem_arbiter.sv
// rtl/cevero_mem_arbiter.sv - two-master req/gnt/rvalid arbiter sharing one memory slave
// Optional round-robin arbitration: define CEVERO_ARB_ROUND_ROBIN_EN (default: fixed priority, data wins).
module cevero_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    proto_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  logic [1:0]                 state, state_nxt;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       fifo_full, fifo_empty, allow, push, pop;
  logic                       sel_data, req_src, tie_data, head_id;

`ifdef CEVERO_ARB_ROUND_ROBIN_EN
  logic last_grant;
  assign tie_data = ~last_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i)     last_grant <= 1'b0;
    else if (push) last_grant <= sel_data;
  end
`else
  assign tie_data = 1'b1;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head_id    = id_q[rd_ptr];
  assign pop        = ~rst_i & mem_rvalid_i & ~fifo_empty;
  // A same-cycle pop frees the slot the new grant will occupy.
  assign allow      = ~fifo_full | pop;

  always_comb begin
    sel_data = 1'b0;
    req_src  = 1'b0;
    case (state)
      LOCK_I: begin sel_data = 1'b0; req_src = instr_req_i; end
      LOCK_D: begin sel_data = 1'b1; req_src = data_req_i;  end
      default: begin
        sel_data = data_req_i & (~instr_req_i | tie_data);
        req_src  = instr_req_i | data_req_i;
      end
    endcase
  end

  assign mem_req_o   = ~rst_i & req_src & allow;
  assign push        = mem_req_o & mem_gnt_i;
  assign mem_we_o    = sel_data & data_we_i;
  assign mem_be_o    = sel_data ? data_be_i : '1;
  assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = sel_data ? data_wdata_i : '0;

  assign instr_gnt_o    = push & ~sel_data;
  assign data_gnt_o     = push & sel_data;
  assign instr_rvalid_o = pop & ~head_id;
  assign data_rvalid_o  = pop & head_id;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req_o & ~mem_gnt_i) state_nxt = sel_data ? LOCK_D : LOCK_I;
      LOCK_I:  if (~instr_req_i | push) state_nxt = IDLE;
      LOCK_D:  if (~data_req_i | push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      id_q        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        id_q[wr_ptr] <= sel_data;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_rvalid_i & fifo_empty) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cevero_mem_arbiter.sv
// tb/tb_cevero_mem_arbiter.sv - directed self-checking bench for cevero_mem_arbiter
module tb_cevero_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, proto_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cevero_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .proto_err_o(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_req = 0; data_req = 0; data_we = 0; data_be = 4'hF;
    instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1; clear_inputs();
    instr_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_instr_gnt", instr_gnt, 0);
    chk("rst_instr_rvalid", instr_rvalid, 0);
    chk("rst_data_rvalid", data_rvalid, 0);
    chk("rst_rdata_follow", instr_rdata, 32'h1234_5678);
    chk("rst_proto_err", proto_err, 0);
    next_cycle(); rst = 0;

    // Tie in IDLE: data first, then instr, responses D then I
    instr_req = 1; instr_addr = 32'h10; data_req = 1; data_addr = 32'h20; mem_gnt = 1; #1;
    chk("tie_data_gnt", data_gnt, 1);
    chk("tie_instr_gnt", instr_gnt, 0);
    chk("tie_addr", mem_addr, 32'h20);
    next_cycle();
    instr_req = 1; instr_addr = 32'h10; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hAAAA; #1;
    chk("tie2_instr_gnt", instr_gnt, 1);
    chk("tie2_data_rvalid", data_rvalid, 1);
    chk("tie2_instr_rvalid", instr_rvalid, 0);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hBBBB; #1;
    chk("tie3_instr_rvalid", instr_rvalid, 1);
    chk("tie3_data_rvalid", data_rvalid, 0);
    chk("tie3_rdata", instr_rdata, 32'hBBBB);

    // Lock on instr while the slave stalls
    next_cycle();
    instr_req = 1; instr_addr = 32'h100; #1;
    chk("lock0_mem_req", mem_req, 1);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      instr_req = 1; instr_addr = 32'h100; data_req = 1; data_addr = 32'h200; #1;
      chk("lock_addr", mem_addr, 32'h100);
      chk("lock_data_gnt", data_gnt, 0);
    end
    next_cycle();
    instr_req = 1; instr_addr = 32'h100; data_req = 1; data_addr = 32'h200; mem_gnt = 1; #1;
    chk("lock_instr_gnt", instr_gnt, 1);
    chk("lock_data_gnt4", data_gnt, 0);
    next_cycle();
    data_req = 1; data_addr = 32'h200; mem_gnt = 1; mem_rvalid = 1; #1;
    chk("lock_then_data_gnt", data_gnt, 1);
    chk("lock_then_instr_rvalid", instr_rvalid, 1);
    next_cycle();
    mem_rvalid = 1; #1;
    chk("lock_data_rvalid", data_rvalid, 1);

    // FIFO full masks requests; a same-cycle pop lets one through
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      instr_req = 1; mem_gnt = 1; #1;
      chk("fill_gnt", instr_gnt, 1);
    end
    next_cycle();
    instr_req = 1; mem_gnt = 1; #1;
    chk("full_mem_req", mem_req, 0);
    chk("full_instr_gnt", instr_gnt, 0);
    next_cycle();
    instr_req = 1; mem_gnt = 1; mem_rvalid = 1; #1;
    chk("full_pop_mem_req", mem_req, 1);
    chk("full_pop_gnt", instr_gnt, 1);
    chk("full_pop_rvalid", instr_rvalid, 1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mem_rvalid = 1; #1;
      chk("drain_rvalid", instr_rvalid, 1);
    end
    next_cycle(); #1;
    chk("drain_no_err", proto_err, 0);

    // Data write forwarded, then instr read returns its data only to instr
    data_req = 1; data_we = 1; data_be = 4'b0011; data_wdata = 32'hDEADBEEF;
    data_addr = 32'h40; mem_gnt = 1; #1;
    chk("wr_we", mem_we, 1);
    chk("wr_be", mem_be, 4'b0011);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_addr", mem_addr, 32'h40);
    chk("wr_gnt", data_gnt, 1);
    next_cycle();
    instr_req = 1; instr_addr = 32'h40; mem_gnt = 1; mem_rvalid = 1; #1;
    chk("rd_we", mem_we, 0);
    chk("rd_be", mem_be, 4'hF);
    chk("rd_wdata", mem_wdata, 32'h0);
    chk("rd_addr", mem_addr, 32'h40);
    chk("wr_resp_data_rvalid", data_rvalid, 1);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h0000BEEF; #1;
    chk("rd_instr_rvalid", instr_rvalid, 1);
    chk("rd_data_rvalid", data_rvalid, 0);
    chk("rd_rdata", instr_rdata, 32'h0000BEEF);

    // rvalid with nothing outstanding
    next_cycle();
    mem_rvalid = 1; #1;
    chk("empty_instr_rvalid", instr_rvalid, 0);
    chk("empty_data_rvalid", data_rvalid, 0);
    next_cycle(); #1;
    chk("empty_proto_err", proto_err, 1);
    next_cycle(); #1;
    chk("sticky_proto_err", proto_err, 1);

    // Reset with one outstanding read and a pending lock
    rst = 1;
    next_cycle(); rst = 0; #1;
    chk("rst2_proto_err", proto_err, 0);
    instr_req = 1; instr_addr = 32'h300; mem_gnt = 1; #1;
    chk("rst2_gnt", instr_gnt, 1);
    next_cycle();
    instr_req = 1; instr_addr = 32'h300; #1;
    next_cycle(); rst = 1;
    next_cycle(); rst = 0;
    mem_rvalid = 1; instr_req = 1; instr_addr = 32'h300; data_req = 1; data_addr = 32'h400; #1;
    chk("rst3_instr_rvalid", instr_rvalid, 0);
    chk("rst3_data_rvalid", data_rvalid, 0);
    chk("rst3_idle_arb_addr", mem_addr, 32'h400);
    next_cycle(); #1;
    chk("rst3_proto_err", proto_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
